// File: rtl/bexkat1_intunit_pkg.sv
// bexkat1Def: shared types for the bexkat1 integer unit.
//   intfunc_t    - integer-unit operation code (codes 12-15 are undefined).
//   intu_state_t - integer-unit sequencing states.
package bexkat1Def;

  typedef enum logic [3:0] {
    INT_MUL   = 4'd0,
    INT_DIV   = 4'd1,
    INT_MOD   = 4'd2,
    INT_MULU  = 4'd3,
    INT_DIVU  = 4'd4,
    INT_MODU  = 4'd5,
    INT_MULX  = 4'd6,
    INT_MULUX = 4'd7,
    INT_EXT   = 4'd8,
    INT_EXTB  = 4'd9,
    INT_COM   = 4'd10,
    INT_NEG   = 4'd11
  } intfunc_t;

  typedef enum logic [2:0] {
    IU_IDLE,
    IU_MUL,
    IU_DIV,
    IU_FIX,
    IU_DONE
  } intu_state_t;

  localparam int unsigned DivSteps = 32;

  function automatic logic is_mul(intfunc_t f);
    return f inside {INT_MUL, INT_MULU, INT_MULX, INT_MULUX};
  endfunction

  function automatic logic is_div(intfunc_t f);
    return f inside {INT_DIV, INT_MOD, INT_DIVU, INT_MODU};
  endfunction

  function automatic logic is_signed_op(intfunc_t f);
    return f inside {INT_MUL, INT_MULX, INT_DIV, INT_MOD};
  endfunction

  function automatic logic is_rem(intfunc_t f);
    return f inside {INT_MOD, INT_MODU};
  endfunction

endpackage

// File: rtl/bexkat1_intunit_divider.sv
// bexkat1_divider: unsigned 32-step restoring divider, one quotient bit per cycle, MSB first.
//   clk_i, rst_i      - clock, synchronous active-high reset
//   start_i           - load operands (ignored-free: restarts any running division)
//   dividend_i/_o etc - unsigned operands; quotient_o/remainder_o valid after done_o
//   done_o            - high during the final iteration cycle; results valid from the next cycle
module bexkat1_divider
  import bexkat1Def::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  // rq_q holds {partial remainder, remaining dividend bits / quotient bits}.
  logic [63:0] rq_q;
  logic [31:0] divisor_q;
  logic [4:0]  cnt_q;
  logic        run_q;

  logic [32:0] partial;
  logic        fits;
  logic [31:0] diff;
  logic [63:0] step;

  always_comb begin
    partial = rq_q[63:31];
    fits    = partial >= {1'b0, divisor_q};
    // When the trial subtraction fits, the difference is below the divisor so 32 bits suffice.
    diff    = partial[31:0] - divisor_q;
    step    = fits ? {diff, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
  end

  assign done_o      = run_q && (cnt_q == 5'd0);
  assign quotient_o  = rq_q[31:0];
  assign remainder_o = rq_q[63:32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rq_q      <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
    end else if (start_i) begin
      rq_q      <= {32'd0, dividend_i};
      divisor_q <= divisor_i;
      cnt_q     <= 5'(DivSteps - 1);
      run_q     <= 1'b1;
    end else if (run_q) begin
      rq_q  <= step;
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bexkat1_intunit.sv
// bexkat1_intunit: multi-cycle integer unit (mul/div/mod/extend/complement/negate).
//   clk_i, rst_i   - clock, synchronous active-high reset
//   start_i        - begin an operation; sampled only in IU_IDLE
//   func_i         - operation code (intfunc_t)
//   in1_i, in2_i   - operands A and B (A is the sole operand for unary ops)
//   busy_o         - high from the cycle after accept through the done_o cycle
//   done_o         - one-cycle pulse, out_o valid; out_o then held until the next result
//   div0_o         - divide/modulo by zero flag, valid with done_o
module bexkat1_intunit
  import bexkat1Def::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  intfunc_t         func_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             div0_o
);

  intu_state_t state_q;
  intfunc_t    func_q;
  logic [31:0] in1_q, in2_q;
  logic [63:0] prod_q;
  logic [31:0] fix_q;
  logic        qneg_q, rneg_q, zero_q;
  logic        busy_q, done_q, div0_q;
  logic [31:0] out_q;

  // Operand magnitudes are taken straight from the inputs so the divider loads at accept.
  logic        a_neg, b_neg, accept, div_start, div_done;
  logic [31:0] a_mag, b_mag, quot_mag, rem_mag;

  always_comb begin
    accept    = (state_q == IU_IDLE) && start_i;
    a_neg     = is_signed_op(func_i) && in1_i[31];
    b_neg     = is_signed_op(func_i) && in2_i[31];
    a_mag     = a_neg ? 32'd0 - in1_i : in1_i;
    b_mag     = b_neg ? 32'd0 - in2_i : in2_i;
    div_start = accept && is_div(func_i);
  end

  bexkat1_divider u_divider (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (div_start),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .done_o      (div_done),
    .quotient_o  (quot_mag),
    .remainder_o (rem_mag)
  );

  // 33x33 signed multiply: the extra top bit selects signed or unsigned interpretation.
  logic [32:0] mul_a, mul_b;
  logic [63:0] prod_next;

  always_comb begin
    mul_a     = {is_signed_op(func_q) & in1_q[31], in1_q};
    mul_b     = {is_signed_op(func_q) & in2_q[31], in2_q};
    prod_next = 64'($signed(mul_a)) * 64'($signed(mul_b));
  end

  logic [31:0] quot_fix, rem_fix, fix_next, result;

  always_comb begin
    // Divide by zero: the iteration leaves the dividend in the remainder; force all-ones quotient.
    quot_fix = zero_q ? 32'hFFFF_FFFF : (qneg_q ? 32'd0 - quot_mag : quot_mag);
    rem_fix  = rneg_q ? 32'd0 - rem_mag : rem_mag;
    fix_next = is_rem(func_q) ? rem_fix : quot_fix;
  end

  always_comb begin
    result = '0;
    case (func_q)
      INT_EXT:                       result = {{16{in1_q[15]}}, in1_q[15:0]};
      INT_EXTB:                      result = {{24{in1_q[7]}}, in1_q[7:0]};
      INT_COM:                       result = ~in1_q;
      INT_NEG:                       result = 32'd0 - in1_q;
      INT_MUL, INT_MULU:             result = prod_q[31:0];
      INT_MULX, INT_MULUX:           result = prod_q[63:32];
      INT_DIV, INT_MOD, INT_DIVU,
      INT_MODU:                      result = fix_q;
      default:                       result = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IU_IDLE;
      func_q  <= INT_MUL;
      in1_q   <= '0;
      in2_q   <= '0;
      prod_q  <= '0;
      fix_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      unique case (state_q)
        IU_IDLE: begin
          if (accept) begin
            func_q <= func_i;
            in1_q  <= in1_i;
            in2_q  <= in2_i;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            zero_q <= (in2_i == 32'd0);
            busy_q <= 1'b1;
            if (is_mul(func_i))      state_q <= IU_MUL;
            else if (is_div(func_i)) state_q <= IU_DIV;
            else                     state_q <= IU_DONE;
          end else begin
            busy_q <= 1'b0;
          end
        end
        IU_MUL: begin
          prod_q  <= prod_next;
          state_q <= IU_DONE;
        end
        IU_DIV: begin
          if (div_done) state_q <= IU_FIX;
        end
        IU_FIX: begin
          fix_q   <= fix_next;
          state_q <= IU_DONE;
        end
        IU_DONE: begin
          done_q  <= 1'b1;
          out_q   <= result;
          div0_q  <= is_div(func_q) && zero_q;
          state_q <= IU_IDLE;
        end
        default: state_q <= IU_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign out_o  = out_q;
  assign div0_o = div0_q;

endmodule
